// File: rtl/prm_mask_pkg.sv
// Shared constants, state encoding and term storage layout for the PRM edge mask engine.
package prm_mask_pkg;

    localparam int unsigned IN_W    = 15;
    localparam int unsigned N_TERMS = 256;
    localparam int unsigned LANES   = 4;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned STAT_W  = 16;

    function automatic int unsigned clog2_u(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) width = i + 1;
        end
        return width;
    endfunction

    localparam int unsigned TI_W     = clog2_u(N_TERMS);
    localparam int unsigned LANE_W   = (LANES > 1) ? clog2_u(LANES) : 1;
    localparam int unsigned LAST_PTR = N_TERMS - LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic            en;
        logic [IN_W-1:0] care;
        logic [IN_W-1:0] val;
    } term_t;

endpackage

// File: rtl/prm_term_lane.sv
// One sum-of-products term compared against a configuration code.
module prm_term_lane
    import prm_mask_pkg::*;
(
    input  term_t           term,
    input  logic [IN_W-1:0] code,
    output logic            hit_c
);

    assign hit_c = term.en && (((code ^ term.val) & term.care) == '0);

endmodule

// File: rtl/prm_edge_mask_engine.sv
// Programmable edge mask engine: scans runtime-loaded terms LANES at a time per query
// and reports whether any enabled term hits plus the lowest hitting index.
module prm_edge_mask_engine
    import prm_mask_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [TI_W-1:0]   cfg_addr,
    input  logic [IN_W-1:0]   cfg_care,
    input  logic [IN_W-1:0]   cfg_val,
    input  logic              cfg_en,
    input  logic              cfg_clr,
    output logic              cfg_ready,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [IN_W-1:0]   q_code,
    input  logic [ID_W-1:0]   q_id,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              r_mask,
    output logic [TI_W-1:0]   r_term,
    output logic [ID_W-1:0]   r_id,
    output logic [STAT_W-1:0] stat_q,
    output logic [STAT_W-1:0] stat_hit
);

    state_t            state_q;
    state_t            state_d;
    term_t             terms [N_TERMS];
    term_t             lane_term [LANES];
    logic [LANES-1:0]  lane_hit;
    logic [IN_W-1:0]   code_q;
    logic [TI_W-1:0]   ptr_q;
    logic [LANE_W-1:0] hit_off;
    logic [TI_W-1:0]   hit_idx;
    logic              any_hit;
    logic              last_group;

    // Current scan group: LANES consecutive terms starting at the aligned pointer.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_term[i] = terms[ptr_q + TI_W'(i)];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        prm_term_lane u_lane (
            .term  (lane_term[g]),
            .code  (code_q),
            .hit_c (lane_hit[g])
        );
    end

    // Lowest hitting lane wins; pointer is LANES-aligned so OR-ing the offset is exact.
    always_comb begin
        hit_off = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_hit[i]) hit_off = LANE_W'(i);
        end
        any_hit    = |lane_hit;
        hit_idx    = ptr_q | TI_W'(hit_off);
        last_group = (ptr_q == TI_W'(LAST_PTR));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (q_valid && q_ready) state_d = SCAN;
            SCAN:    if (any_hit || last_group) state_d = DONE;
            DONE:    if (r_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags follow the next state, so they never depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_ready   <= 1'b0;
            cfg_ready <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            q_ready   <= (state_d == IDLE);
            cfg_ready <= (state_d == IDLE);
            r_valid   <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= '0;
            ptr_q    <= '0;
            r_mask   <= 1'b0;
            r_term   <= '0;
            r_id     <= '0;
            stat_q   <= '0;
            stat_hit <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (q_valid && q_ready) begin
                        code_q <= q_code;
                        r_id   <= q_id;
                        ptr_q  <= '0;
                    end
                end
                SCAN: begin
                    if (any_hit) begin
                        r_mask <= 1'b1;
                        r_term <= hit_idx;
                    end else if (last_group) begin
                        r_mask <= 1'b0;
                        r_term <= '0;
                    end else begin
                        ptr_q <= ptr_q + TI_W'(LANES);
                    end
                end
                DONE: begin
                    if (r_ready) begin
                        stat_q <= stat_q + STAT_W'(1);
                        if (r_mask) stat_hit <= stat_hit + STAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Term table: clear-all lands before a same-cycle write; only accepted while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_TERMS; i++) terms[i].en <= 1'b0;
        end else if (cfg_ready) begin
            if (cfg_clr) begin
                for (int i = 0; i < N_TERMS; i++) terms[i].en <= 1'b0;
            end
            if (cfg_we) begin
                terms[cfg_addr].en   <= cfg_en;
                terms[cfg_addr].care <= cfg_care;
                terms[cfg_addr].val  <= cfg_val;
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// Directed self-checking bench for prm_edge_mask_engine.
module tb_prm_edge_mask_engine;
    import prm_mask_pkg::*;

    logic              clk;
    logic              rst;
    logic              cfg_we;
    logic [TI_W-1:0]   cfg_addr;
    logic [IN_W-1:0]   cfg_care;
    logic [IN_W-1:0]   cfg_val;
    logic              cfg_en;
    logic              cfg_clr;
    logic              cfg_ready;
    logic              q_valid;
    logic              q_ready;
    logic [IN_W-1:0]   q_code;
    logic [ID_W-1:0]   q_id;
    logic              r_valid;
    logic              r_ready;
    logic              r_mask;
    logic [TI_W-1:0]   r_term;
    logic [ID_W-1:0]   r_id;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_hit;

    int total;
    int bad;

    prm_edge_mask_engine dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .cfg_en    (cfg_en),
        .cfg_clr   (cfg_clr),
        .cfg_ready (cfg_ready),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_code    (q_code),
        .q_id      (q_id),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_mask    (r_mask),
        .r_term    (r_term),
        .r_id      (r_id),
        .stat_q    (stat_q),
        .stat_hit  (stat_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cfg_write(input int addr, input logic [IN_W-1:0] care,
                             input logic [IN_W-1:0] val, input logic en);
        cfg_addr = TI_W'(addr); cfg_care = care; cfg_val = val; cfg_en = en; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_clear();
        cfg_clr = 1'b1;
        @(posedge clk); #1;
        cfg_clr = 1'b0;
    endtask

    // Latency counts edges from the cycle q_valid is driven to the first cycle r_valid is seen.
    task automatic run_query(input logic [IN_W-1:0] code, input logic [ID_W-1:0] id, output int lat);
        q_code = code; q_id = id; q_valid = 1'b1; lat = 0;
        @(posedge clk); #1;
        q_valid = 1'b0; lat = 1;
        while (r_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_result();
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (q_ready !== 1'b0) begin bad++; $display("FAIL reset_q_ready got=%0b exp=0", q_ready); end
        total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_cfg_ready got=%0b exp=0", cfg_ready); end
        total++; if (r_valid !== 1'b0 || r_mask !== 1'b0 || r_term !== '0 || r_id !== '0) begin
            bad++; $display("FAIL reset_result got v=%0b m=%0b t=%0d id=%0h exp 0/0/0/0", r_valid, r_mask, r_term, r_id); end
        total++; if (stat_q !== '0 || stat_hit !== '0) begin
            bad++; $display("FAIL reset_stats got q=%0d hit=%0d exp 0/0", stat_q, stat_hit); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (q_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release_ready got q=%0b cfg=%0b exp 1/1", q_ready, cfg_ready); end
    endtask

    task automatic test_full_miss();
        int lat;
        run_query(15'h4A5D, 8'h11, lat);
        total++; if (lat !== 65) begin bad++; $display("FAIL miss_latency got=%0d exp=65", lat); end
        total++; if (r_mask !== 1'b0 || r_term !== '0 || r_id !== 8'h11) begin
            bad++; $display("FAIL miss_result got m=%0b t=%0d id=%0h exp 0/0/11", r_mask, r_term, r_id); end
        release_result();
        total++; if (stat_q !== 16'd1 || stat_hit !== 16'd0) begin
            bad++; $display("FAIL miss_stats got q=%0d hit=%0d exp 1/0", stat_q, stat_hit); end
    endtask

    task automatic test_group2_hit();
        int lat;
        cfg_write(9, 15'h7FFF, 15'h1234, 1'b1);
        run_query(15'h1234, 8'h5A, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL g2_latency got=%0d exp=4", lat); end
        total++; if (r_mask !== 1'b1 || r_term !== 8'd9 || r_id !== 8'h5A) begin
            bad++; $display("FAIL g2_result got m=%0b t=%0d id=%0h exp 1/9/5a", r_mask, r_term, r_id); end
        release_result();
        total++; if (stat_q !== 16'd2 || stat_hit !== 16'd1) begin
            bad++; $display("FAIL g2_stats got q=%0d hit=%0d exp 2/1", stat_q, stat_hit); end
        run_query(15'h1235, 8'h5B, lat);
        total++; if (lat !== 65 || r_mask !== 1'b0 || r_term !== '0) begin
            bad++; $display("FAIL care_miss got lat=%0d m=%0b t=%0d exp 65/0/0", lat, r_mask, r_term); end
        release_result();
    endtask

    task automatic test_priority();
        int lat;
        cfg_write(5, 15'h0000, 15'h0000, 1'b1);
        cfg_write(6, 15'h7FFF, 15'h0F0F, 1'b1);
        run_query(15'h0F0F, 8'h21, lat);
        total++; if (lat !== 3 || r_mask !== 1'b1 || r_term !== 8'd5) begin
            bad++; $display("FAIL prio_lowest got lat=%0d m=%0b t=%0d exp 3/1/5", lat, r_mask, r_term); end
        release_result();
        cfg_clear();
        cfg_write(200, 15'h00FF, 15'h0055, 1'b1);
        run_query(15'h3355, 8'h22, lat);
        total++; if (lat !== 52 || r_mask !== 1'b1 || r_term !== 8'd200 || r_id !== 8'h22) begin
            bad++; $display("FAIL term200 got lat=%0d m=%0b t=%0d id=%0h exp 52/1/200/22", lat, r_mask, r_term, r_id); end
        release_result();
        total++; if (stat_q !== 16'd5 || stat_hit !== 16'd3) begin
            bad++; $display("FAIL prio_stats got q=%0d hit=%0d exp 5/3", stat_q, stat_hit); end
    endtask

    task automatic test_backpressure();
        int lat;
        run_query(15'h0055, 8'h77, lat);
        total++; if (lat !== 52 || q_ready !== 1'b0) begin
            bad++; $display("FAIL bp_arrive got lat=%0d q_ready=%0b exp 52/0", lat, q_ready); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (r_valid !== 1'b1 || r_mask !== 1'b1 || r_term !== 8'd200 || r_id !== 8'h77 || q_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc=%0d got v=%0b m=%0b t=%0d id=%0h qr=%0b exp 1/1/200/77/0",
                                i, r_valid, r_mask, r_term, r_id, q_ready);
            end
        end
        release_result();
        total++; if (r_valid !== 1'b0 || q_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got v=%0b qr=%0b exp 0/1", r_valid, q_ready); end
    endtask

    task automatic test_cfg_same_cycle();
        int lat;
        cfg_clr = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_care = '0; cfg_val = 15'h1111; cfg_en = 1'b1;
        q_code = 15'h7ABC; q_id = 8'h33; q_valid = 1'b1;
        @(posedge clk); #1;
        cfg_clr = 1'b0; cfg_we = 1'b0; q_valid = 1'b0; lat = 1;
        while (r_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 2 || r_mask !== 1'b1 || r_term !== 8'd0 || r_id !== 8'h33) begin
            bad++; $display("FAIL same_cycle got lat=%0d m=%0b t=%0d id=%0h exp 2/1/0/33", lat, r_mask, r_term, r_id); end
        release_result();
        cfg_clear();
        q_code = 15'h0001; q_id = 8'h44; q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        @(posedge clk); #1;
        cfg_write(3, 15'h0000, 15'h0000, 1'b1);
        lat = 3;
        while (r_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 65 || r_mask !== 1'b0) begin
            bad++; $display("FAIL scan_write got lat=%0d m=%0b exp 65/0", lat, r_mask); end
        release_result();
        run_query(15'h0002, 8'h45, lat);
        total++; if (lat !== 65 || r_mask !== 1'b0 || r_term !== '0) begin
            bad++; $display("FAIL scan_write_after got lat=%0d m=%0b t=%0d exp 65/0/0", lat, r_mask, r_term); end
        release_result();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        logic seen;
        cfg_write(200, 15'h0000, 15'h0000, 1'b1);
        q_code = 15'h0ABC; q_id = 8'h66; q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (q_ready !== 1'b0 || cfg_ready !== 1'b0 || r_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_hold got qr=%0b cr=%0b v=%0b exp 0/0/0", q_ready, cfg_ready, r_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (q_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%0b exp=1", q_ready); end
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (r_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_result got r_valid seen=%0b exp=0", seen); end
        run_query(15'h0ABC, 8'h67, lat);
        total++; if (lat !== 65 || r_mask !== 1'b0 || r_id !== 8'h67) begin
            bad++; $display("FAIL midrst_terms_off got lat=%0d m=%0b id=%0h exp 65/0/67", lat, r_mask, r_id); end
        release_result();
        total++; if (stat_q !== 16'd1 || stat_hit !== 16'd0) begin
            bad++; $display("FAIL midrst_stats got q=%0d hit=%0d exp 1/0", stat_q, stat_hit); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_en = 1'b0;
        cfg_clr = 1'b0; q_valid = 1'b0; q_code = '0; q_id = '0; r_ready = 1'b0;
        test_reset();
        test_full_miss();
        test_group2_hit();
        test_priority();
        test_backpressure();
        test_cfg_same_cycle();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
